// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (START_BYTE, length N, 4*N
// little-endian data bytes, 8-bit additive checksum) and writes the
// assembled 32-bit words into the instruction RAM at addresses 0..N-1.
// The CPU is held from frame start until a frame ends with a good checksum.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   rx_data, rx_valid     incoming byte stream
//   rx_ready              byte accepted when rx_valid && rx_ready at a rising edge
//   we, waddr, wdata      instruction RAM write port (one-cycle pulse per word)
//   cpu_hold              CPU must be held while high
//   done                  one-cycle pulse after a successful load
//   err                   sticky checksum-error flag, cleared by the next frame start
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter logic [7:0]  START_BYTE = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    // Word counters need one extra bit so a full-depth count is representable.
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer;
    logic [31:0]           word_next;
    logic [CNT_W-1:0]      idx_inc;

    assign xfer      = rx_valid && rx_ready_q;
    // Bytes arrive LSB first, so shift in from the top.
    assign word_next = {rx_data, word_q[31:8]};
    assign idx_inc   = idx_q + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        csum_d     = csum_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_hold_d = cpu_hold_q;
        err_d      = err_q;
        we_d       = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (xfer && (rx_data == START_BYTE)) begin
                    state_d    = S_LEN;
                    cpu_hold_d = 1'b1;
                    err_d      = 1'b0;
                    csum_d     = 8'd0;
                    idx_d      = '0;
                    byte_cnt_d = 2'd0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    // Zero means full depth; oversize counts clamp to full depth.
                    if ((rx_data == 8'd0) || (32'(rx_data) > DEPTH)) begin
                        count_d = CNT_W'(DEPTH);
                    end else begin
                        count_d = CNT_W'(rx_data);
                    end
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = word_next;
                    csum_d     = csum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        waddr_d = idx_q[ADDR_WIDTH-1:0];
                        wdata_d = word_next;
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == count_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data == csum_q) begin
                        cpu_hold_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // No byte is taken in the cycle the RAM write is issued.
        rx_ready_d = (state_d != S_WRITE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            csum_q     <= 8'd0;
            rx_ready_q <= 1'b1;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test of imem_loader. Inputs change on the falling
// edge, outputs are sampled on the falling edge; a monitor logs every write.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Write log filled by the monitor.
    logic [5:0]  wr_addr [0:511];
    logic [31:0] wr_data [0:511];
    int          wr_count = 0;
    int          done_count = 0;
    int          ready_during_we = 0;

    imem_loader #(.ADDR_WIDTH(6), .START_BYTE(8'hA5)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (we) begin
            if (wr_count < 512) begin
                wr_addr[wr_count] = waddr;
                wr_data[wr_count] = wdata;
            end
            wr_count++;
            if (rx_ready) ready_during_we++;
        end
        if (done) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a byte (called at a falling edge) and return at the falling edge
    // after it was accepted. rx_valid is left high for back-to-back streaming.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $error("FAIL rx_ready_timeout: observed 0 expected 1");
        end
        @(negedge clock);
    endtask

    task automatic stop_tx();
        rx_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_frame_05(input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(cs);
    endtask

    initial begin
        int base;
        int bad;

        // Reset values
        @(negedge clock);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_rx_ready", 32'(rx_ready), 32'd1);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd0);

        // Good single-word frame, cycle-accurate checks
        base = wr_count;
        send_byte(8'hA5);
        check("f1_hold_after_start", 32'(cpu_hold), 32'd1);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h01);
        check("f1_no_we_early", 32'(we), 32'd0);
        send_byte(8'h20);
        check("f1_we", 32'(we), 32'd1);
        check("f1_rx_ready_low", 32'(rx_ready), 32'd0);
        check("f1_waddr", 32'(waddr), 32'd0);
        check("f1_wdata", wdata, 32'h20010005);
        check("f1_hold_mid", 32'(cpu_hold), 32'd1);
        send_byte(8'h26);
        check("f1_done", 32'(done), 32'd1);
        check("f1_hold_released", 32'(cpu_hold), 32'd0);
        check("f1_err", 32'(err), 32'd0);
        stop_tx();
        check("f1_done_one_cycle", 32'(done), 32'd0);
        check("f1_write_count", 32'(wr_count - base), 32'd1);

        // Bad checksum, then recovery
        base = wr_count;
        send_frame_05(8'h27);
        check("f2_err", 32'(err), 32'd1);
        check("f2_hold_stays", 32'(cpu_hold), 32'd1);
        check("f2_no_done", 32'(done), 32'd0);
        stop_tx();
        check("f2_err_sticky", 32'(err), 32'd1);
        check("f2_write_count", 32'(wr_count - base), 32'd1);
        check("f2_wdata", wr_data[base], 32'h20010005);
        send_byte(8'hA5);
        check("f3_err_cleared", 32'(err), 32'd0);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h26);
        check("f3_done", 32'(done), 32'd1);
        check("f3_hold", 32'(cpu_hold), 32'd0);
        stop_tx();

        // Garbage ignored, then N=2 with A5 inside the payload
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        stop_tx();
        check("garbage_hold", 32'(cpu_hold), 32'd0);
        check("garbage_err", 32'(err), 32'd0);
        base = wr_count;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h81);
        check("f4_done", 32'(done), 32'd1);
        check("f4_err", 32'(err), 32'd0);
        stop_tx();
        check("f4_write_count", 32'(wr_count - base), 32'd2);
        check("f4_addr0", 32'(wr_addr[base]), 32'd0);
        check("f4_data0", wr_data[base], 32'h332211A5);
        check("f4_addr1", 32'(wr_addr[base + 1]), 32'd1);
        check("f4_data1", wr_data[base + 1], 32'h77665544);

        // N=0 means full depth: 256 bytes of 0x01, checksum 0x00
        base = wr_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'h01);
        send_byte(8'h00);
        check("f5_done", 32'(done), 32'd1);
        check("f5_hold", 32'(cpu_hold), 32'd0);
        stop_tx();
        check("f5_write_count", 32'(wr_count - base), 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (wr_addr[base + i] !== 6'(i) || wr_data[base + i] !== 32'h01010101) bad++;
        end
        check("f5_bad_words", 32'(bad), 32'd0);

        // N=0xC8 clamps to 64 words; byte after word 63 is the checksum
        base = wr_count;
        send_byte(8'hA5);
        send_byte(8'hC8);
        for (int i = 0; i < 256; i++) send_byte(8'h02);
        send_byte(8'h00);
        check("f6_clamp_done", 32'(done), 32'd1);
        stop_tx();
        check("f6_write_count", 32'(wr_count - base), 32'd64);
        check("f6_last_addr", 32'(wr_addr[base + 63]), 32'd63);
        check("f6_last_data", wr_data[base + 63], 32'h02020202);

        // Reset mid-frame after 6 bytes, then a clean frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        send_byte(8'h40);
        rx_valid = 1'b0;
        check("f7_hold_before_rst", 32'(cpu_hold), 32'd1);
        reset = 1'b1;
        #1;
        check("f7_rst_we", 32'(we), 32'd0);
        check("f7_rst_hold", 32'(cpu_hold), 32'd0);
        check("f7_rst_rx_ready", 32'(rx_ready), 32'd1);
        check("f7_rst_waddr", 32'(waddr), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        base = wr_count;
        send_frame_05(8'h26);
        check("f8_done", 32'(done), 32'd1);
        check("f8_hold", 32'(cpu_hold), 32'd0);
        stop_tx();
        check("f8_write_count", 32'(wr_count - base), 32'd1);
        check("f8_wdata", wr_data[base], 32'h20010005);

        // Global monitor checks: 1+1+1+2+64+64+1(aborted)+1 writes, 6 done pulses
        check("total_writes", 32'(wr_count), 32'd135);
        check("total_done", 32'(done_count), 32'd6);
        check("ready_during_we", 32'(ready_during_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
